ifu_fetch_queue: RTL and testbench

//  Instruction fetch queue between the PC register / instruction memory (IF) and decode (ID).

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_queue_ram.sv | 26 ++
 rtl/ifu_fetch_queue.sv | 119 +++++++++++
 tb/tb_ifu_fetch_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Defining FETCH_EXC_EN adds a 5-bit exception code to each queue entry.
package fetch_pkg;

    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
`ifdef FETCH_EXC_EN
        logic [4:0]  exc;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Misaligned, or outside [base, base+bytes); the limit is computed in 33 bits so it cannot wrap.
    function automatic logic fetch_addr_err(input logic [31:0] pc,
                                            input logic [31:0] base,
                                            input logic [31:0] bytes);
        logic [32:0] lim;
        lim = {1'b0, base} + {1'b0, bytes};
        return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= lim);
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Register-array storage for the fetch queue.
// It has one synchronous write port and one asynchronous read port, and no reset.
module fetch_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch queue buffering {pc, instr} pairs between IF and ID, with flush on redirect.
// Defining FETCH_EXC_EN tags bad fetch addresses with EXC_ADEL and adds the out_exc port.
module ifu_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES = 32'h0000_4000
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     FLUSH,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_EXC_EN
    ,
    output logic [4:0]               out_exc
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (IM_BASE[1:0] != 2'b00 || IM_BYTES == 32'd0) begin : g_bad_im
        $error("IM_BASE must be word aligned and IM_BYTES nonzero");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push, pop;
    fetch_entry_t wr_entry, rd_entry;

    assign in_ready  = (count_q != CW'(DEPTH)) && !FLUSH;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !FLUSH;
    assign count     = count_q;

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = in_pc;
        wr_entry.instr = in_instr;
`ifdef FETCH_EXC_EN
        wr_entry.exc   = fetch_addr_err(in_pc, IM_BASE, IM_BYTES) ? EXC_ADEL : EXC_NONE;
        if (wr_entry.exc != EXC_NONE) begin
            wr_entry.instr = NOP_INSTR;
        end
`endif
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared, so stale data is masked whenever the queue is empty.
    assign out_pc    = out_valid ? rd_entry.pc    : 32'h0;
    assign out_instr = out_valid ? rd_entry.instr : 32'h0;
`ifdef FETCH_EXC_EN
    assign out_exc   = out_valid ? rd_entry.exc   : EXC_NONE;
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed self-checking bench for ifu_fetch_queue (DEPTH=4).
// With FETCH_EXC_EN defined it also checks the exception tagging of bad fetch addresses.
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        RESET;
    logic        FLUSH;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;
`ifdef FETCH_EXC_EN
    logic [4:0]  out_exc;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifu_fetch_queue #(
        .DEPTH    (4),
        .IM_BASE  (32'h0000_3000),
        .IM_BYTES (32'h0000_4000)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
`ifdef FETCH_EXC_EN
        ,
        .out_exc   (out_exc)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = pc ^ 32'hCAFE_0000;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        #1;
        step();
        step();
        RESET = 1'b0;
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_pc", out_pc, 32'h0);
        check_val("rst_instr", out_instr, 32'h0);
        check_val("rst_ready", 32'(in_ready), 32'd1);
`ifdef FETCH_EXC_EN
        check_val("rst_exc", 32'(out_exc), 32'd0);
`endif

        // 1: three pushes, no pops
        push_one(32'h3000);
        check_val("t1_first_visible", out_pc, 32'h3000);
        push_one(32'h3004);
        push_one(32'h3008);
        check_val("t1_count", 32'(count), 32'd3);
        check_val("t1_pc", out_pc, 32'h3000);
        check_val("t1_instr", out_instr, 32'hCAFE_3000);
        check_val("t1_valid", 32'(out_valid), 32'd1);

        // 2: fill, dropped push, pop alone from full
        push_one(32'h300C);
        check_val("t2_full_count", 32'(count), 32'd4);
        check_val("t2_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_pc = 32'h3010; in_instr = 32'hBAD0_0000;
        step();
        in_valid = 1'b0;
        check_val("t2_drop_count", 32'(count), 32'd4);
        pop_one();
        check_val("t2_pop_count", 32'(count), 32'd3);
        check_val("t2_pop_ready", 32'(in_ready), 32'd1);
        check_val("t2_pop_pc", out_pc, 32'h3004);

        // 3: steady push+pop at count 2 across pointer wrap
        pop_one();
        check_val("t3_start_count", 32'(count), 32'd2);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("t3_head_%0d", i), out_pc, 32'h3008 + 32'(4 * i));
            in_valid = 1'b1; out_ready = 1'b1;
            in_pc = 32'h3010 + 32'(4 * i);
            in_instr = in_pc ^ 32'hCAFE_0000;
            step();
            check_val($sformatf("t3_count_%0d", i), 32'(count), 32'd2);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("t3_end_pc", out_pc, 32'h3030);
        check_val("t3_end_instr", out_instr, 32'hCAFE_3030);

        // 4: flush with count 3 while pushing and popping
        push_one(32'h3038);
        check_val("t4_pre_count", 32'(count), 32'd3);
        FLUSH = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h4000;
        #1;
        check_val("t4_flush_ready", 32'(in_ready), 32'd0);
        step();
        FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_val("t4_count", 32'(count), 32'd0);
        check_val("t4_valid", 32'(out_valid), 32'd0);
        check_val("t4_pc", out_pc, 32'h0);
        check_val("t4_instr", out_instr, 32'h0);
        push_one(32'h3100);
        check_val("t4_after_count", 32'(count), 32'd1);
        check_val("t4_after_pc", out_pc, 32'h3100);
        pop_one();
        check_val("t4_drain", 32'(count), 32'd0);

        // 5: reset mid-operation
        push_one(32'h3200);
        push_one(32'h3204);
        check_val("t5_pre_count", 32'(count), 32'd2);
        RESET = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h3300;
        step();
        RESET = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        check_val("t5_count", 32'(count), 32'd0);
        check_val("t5_valid", 32'(out_valid), 32'd0);
        check_val("t5_pc", out_pc, 32'h0);
        check_val("t5_instr", out_instr, 32'h0);
        push_one(32'h3400);
        check_val("t5_after_count", 32'(count), 32'd1);
        check_val("t5_after_pc", out_pc, 32'h3400);
        pop_one();

`ifdef FETCH_EXC_EN
        // 6: exception tagging
        in_valid = 1'b1; in_instr = 32'hDEAD_BEEF;
        in_pc = 32'h3002; step();
        in_pc = 32'h1000; step();
        in_pc = 32'h3000; step();
        in_pc = 32'h7000; step();
        in_valid = 1'b0;
        check_val("t6_count", 32'(count), 32'd4);
        check_val("t6a_pc", out_pc, 32'h3002);
        check_val("t6a_exc", 32'(out_exc), 32'd4);
        check_val("t6a_instr", out_instr, 32'h0);
        pop_one();
        check_val("t6b_pc", out_pc, 32'h1000);
        check_val("t6b_exc", 32'(out_exc), 32'd4);
        check_val("t6b_instr", out_instr, 32'h0);
        pop_one();
        check_val("t6c_exc", 32'(out_exc), 32'd0);
        check_val("t6c_instr", out_instr, 32'hDEAD_BEEF);
        pop_one();
        check_val("t6d_limit_exc", 32'(out_exc), 32'd4);
        pop_one();
        check_val("t6_empty_exc", 32'(out_exc), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
